// File: rtl/serial_adder_n_if.sv
// Operand/result bundle for the bit-serial adder: start/busy/done framing plus data.
interface serial_adder_n_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first,
// one bit per clock, framed by a start/busy/done handshake.
module serial_adder_n #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  serial_adder_n_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             bit_s;
  logic             carry_nxt;
  logic             last_bit;
  logic [WIDTH-1:0] r_nxt;

  // Full-adder cell on the current LSBs; result shifts in from the MSB side.
  always_comb begin
    bit_s     = a_sh[0] ^ b_sh[0] ^ carry;
    carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    last_bit  = (cnt == CW'(WIDTH - 1));
    r_nxt     = WIDTH'({bit_s, r_sh} >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE, giving back-to-back issue.
        IDLE, DONE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.sub ? ~bus.b : bus.b;
            carry  <= bus.sub ? 1'b1 : bus.cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_nxt;
          carry <= carry_nxt;
          cnt   <= cnt + CW'(1);
          // On the MSB, carry still holds the carry into that bit.
          if (last_bit) begin
            sum_q  <= r_nxt;
            cout_q <= carry_nxt;
            ovf_q  <= carry ^ carry_nxt;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n at WIDTH 8, 3 and 1.
module tb_serial_adder_n;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;

  int          sel;
  logic        t_start;
  logic        t_sub;
  logic        t_cin;
  logic [63:0] t_a;
  logic [63:0] t_b;

  logic        m_busy;
  logic        m_done;
  logic [63:0] m_sum;
  logic        m_cout;
  logic        m_ovf;

  exp_t q[$];
  int   checks;
  int   failures;

  serial_adder_n_if #(.WIDTH(8)) if8 ();
  serial_adder_n_if #(.WIDTH(3)) if3 ();
  serial_adder_n_if #(.WIDTH(1)) if1 ();

  serial_adder_n #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8));
  serial_adder_n #(.WIDTH(3)) u3 (.clk(clk), .rst(rst), .bus(if3));
  serial_adder_n #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .bus(if1));

  assign if8.start = t_start && (sel == 0);
  assign if8.sub   = t_sub;
  assign if8.cin   = t_cin;
  assign if8.a     = t_a[7:0];
  assign if8.b     = t_b[7:0];
  assign if3.start = t_start && (sel == 1);
  assign if3.sub   = t_sub;
  assign if3.cin   = t_cin;
  assign if3.a     = t_a[2:0];
  assign if3.b     = t_b[2:0];
  assign if1.start = t_start && (sel == 2);
  assign if1.sub   = t_sub;
  assign if1.cin   = t_cin;
  assign if1.a     = t_a[0:0];
  assign if1.b     = t_b[0:0];

  always_comb begin
    case (sel)
      0: begin
        m_busy = if8.busy; m_done = if8.done; m_sum = 64'(if8.sum);
        m_cout = if8.cout; m_ovf = if8.ovf;
      end
      1: begin
        m_busy = if3.busy; m_done = if3.done; m_sum = 64'(if3.sum);
        m_cout = if3.cout; m_ovf = if3.ovf;
      end
      default: begin
        m_busy = if1.busy; m_done = if1.done; m_sum = 64'(if1.sum);
        m_cout = if1.cout; m_ovf = if1.ovf;
      end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int w_of();
    case (sel)
      0:       return 8;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  // Reference: plain integer add; overflow from operand/result sign bits.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic sb);
    logic [64:0] mask;
    logic [64:0] bb;
    logic [64:0] aa;
    logic [64:0] tot;
    exp_t r;
    mask  = (65'd1 << w) - 65'd1;
    aa    = {1'b0, a} & mask;
    bb    = sb ? (~{1'b0, b}) & mask : {1'b0, b} & mask;
    tot   = aa + bb + (sb ? 65'd1 : 65'(ci));
    r.sum  = 64'(tot & mask);
    r.cout = tot[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (tot[w-1] != aa[w-1]);
    return r;
  endfunction

  task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic ci,
                        input logic sb);
    q.push_back(model(w_of(), a, b, ci, sb));
    t_a = a; t_b = b; t_cin = ci; t_sub = sb; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt, output bit both);
    lat = 0; bcnt = 0; both = 1'b0;
    while (m_done !== 1'b1 && lat < 64) begin
      if (m_busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
      if (m_busy === 1'b1 && m_done === 1'b1) both = 1'b1;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    sel = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    e = '0;
    checks++;
    if ({m_busy, m_done, m_sum, m_cout, m_ovf} !== {2'b00, e.sum, e.cout, e.ovf}) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
               m_busy, m_done, m_sum, m_cout, m_ovf);
    end
    #3 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_carry();
    int lat; int bcnt; bit both; exp_t e;
    sel = 0;
    launch(64'hFF, 64'h01, 1'b0, 1'b0);
    wait_done(lat, bcnt, both);
    e = q.pop_front();
    checks++;
    if (lat != 8) begin
      failures++; $display("FAIL add_ff01_latency got %0d exp 8", lat);
    end
    checks++;
    if (bcnt != 8) begin
      failures++; $display("FAIL add_ff01_busy_cycles got %0d exp 8", bcnt);
    end
    checks++;
    if (both) begin
      failures++; $display("FAIL add_ff01_busy_done_overlap got 1 exp 0");
    end
    checks++;
    if (m_sum !== e.sum || m_cout !== e.cout || m_ovf !== e.ovf) begin
      failures++;
      $display("FAIL add_ff01_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
               m_sum, m_cout, m_ovf, e.sum, e.cout, e.ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (m_done !== 1'b0 || m_busy !== 1'b0) begin
      failures++; $display("FAIL done_one_cycle got done=%b busy=%b exp 0 0", m_done, m_busy);
    end
  endtask

  task automatic test_add_ovf_sub();
    int lat; int bcnt; bit both; exp_t e;
    sel = 0;
    launch(64'h7F, 64'h01, 1'b0, 1'b0);
    wait_done(lat, bcnt, both);
    e = q.pop_front();
    checks++;
    if (lat != 8 || m_sum !== e.sum || m_cout !== e.cout || m_ovf !== e.ovf) begin
      failures++;
      $display("FAIL add_7f01 got lat=%0d sum=%h cout=%b ovf=%b exp lat=8 sum=%h cout=%b ovf=%b",
               lat, m_sum, m_cout, m_ovf, e.sum, e.cout, e.ovf);
    end
    @(posedge clk); #1;
    launch(64'h05, 64'h07, 1'b1, 1'b1);
    wait_done(lat, bcnt, both);
    e = q.pop_front();
    checks++;
    if (lat != 8 || m_sum !== e.sum || m_cout !== e.cout || m_ovf !== e.ovf) begin
      failures++;
      $display("FAIL sub_0507 got lat=%0d sum=%h cout=%b ovf=%b exp lat=8 sum=%h cout=%b ovf=%b",
               lat, m_sum, m_cout, m_ovf, e.sum, e.cout, e.ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive_w3();
    int lat; int bcnt; bit both; exp_t e; int bad;
    sel = 1;
    bad = 0;
    for (int ai = 0; ai < 8; ai++) begin
      for (int bi = 0; bi < 8; bi++) begin
        for (int c = 0; c < 2; c++) begin
          for (int s = 0; s < 2; s++) begin
            launch(64'(ai), 64'(bi), 1'(c), 1'(s));
            wait_done(lat, bcnt, both);
            e = q.pop_front();
            checks++;
            if (lat != 3 || both || m_sum !== e.sum || m_cout !== e.cout || m_ovf !== e.ovf) begin
              failures++;
              $display("FAIL w3_a%0d_b%0d_c%0d_s%0d got lat=%0d sum=%h cout=%b ovf=%b exp lat=3 sum=%h cout=%b ovf=%b",
                       ai, bi, c, s, lat, m_sum, m_cout, m_ovf, e.sum, e.cout, e.ovf);
            end
          end
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int lat; int bcnt; bit both; exp_t e;
    sel = 0;
    launch(64'h3C, 64'h11, 1'b1, 1'b0);
    @(posedge clk); #1;
    t_a = 64'hAA; t_b = 64'h55; t_sub = 1'b1; t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0;
    wait_done(lat, bcnt, both);
    e = q.pop_front();
    checks++;
    if (lat + 2 != 8) begin
      failures++; $display("FAIL busy_ignore_latency got %0d exp 8", lat + 2);
    end
    checks++;
    if (m_sum !== e.sum || m_cout !== e.cout || m_ovf !== e.ovf) begin
      failures++;
      $display("FAIL busy_ignore_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
               m_sum, m_cout, m_ovf, e.sum, e.cout, e.ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (m_busy !== 1'b0) begin
      failures++; $display("FAIL busy_ignore_not_queued got busy=%b exp 0", m_busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat; int bcnt; bit both; exp_t e1; exp_t e2;
    sel = 0;
    launch(64'h9A, 64'h27, 1'b0, 1'b0);
    wait_done(lat, bcnt, both);
    e1 = q.pop_front();
    checks++;
    if (m_sum !== e1.sum || m_cout !== e1.cout || m_ovf !== e1.ovf) begin
      failures++;
      $display("FAIL b2b_first got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
               m_sum, m_cout, m_ovf, e1.sum, e1.cout, e1.ovf);
    end
    launch(64'h12, 64'hC8, 1'b0, 1'b1);
    checks++;
    if (m_busy !== 1'b1 || m_done !== 1'b0) begin
      failures++; $display("FAIL b2b_no_bubble got busy=%b done=%b exp 1 0", m_busy, m_done);
    end
    checks++;
    if (m_sum !== e1.sum) begin
      failures++; $display("FAIL b2b_sum_held got %h exp %h", m_sum, e1.sum);
    end
    wait_done(lat, bcnt, both);
    e2 = q.pop_front();
    checks++;
    if (lat != 8 || m_sum !== e2.sum || m_cout !== e2.cout || m_ovf !== e2.ovf) begin
      failures++;
      $display("FAIL b2b_second got lat=%0d sum=%h cout=%b ovf=%b exp lat=8 sum=%h cout=%b ovf=%b",
               lat, m_sum, m_cout, m_ovf, e2.sum, e2.cout, e2.ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat; int bcnt; bit both; exp_t e;
    sel = 0;
    launch(64'h33, 64'h44, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (m_busy !== 1'b1 || m_sum === 64'h0) begin
      failures++; $display("FAIL rst_mid_pre got busy=%b sum=%h exp busy=1 sum!=0", m_busy, m_sum);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_busy, m_done, m_sum, m_cout, m_ovf} !== 67'h0) begin
      failures++;
      $display("FAIL rst_mid_async got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
               m_busy, m_done, m_sum, m_cout, m_ovf);
    end
    q.delete();
    #1 rst = 1'b0;
    @(posedge clk); #1;
    launch(64'h10, 64'h20, 1'b0, 1'b0);
    wait_done(lat, bcnt, both);
    e = q.pop_front();
    checks++;
    if (lat != 8 || m_sum !== e.sum || m_cout !== e.cout || m_ovf !== e.ovf) begin
      failures++;
      $display("FAIL rst_mid_after got lat=%0d sum=%h cout=%b ovf=%b exp lat=8 sum=%h cout=%b ovf=%b",
               lat, m_sum, m_cout, m_ovf, e.sum, e.cout, e.ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_width1();
    int lat; int bcnt; bit both; exp_t e;
    sel = 2;
    launch(64'h1, 64'h1, 1'b1, 1'b0);
    wait_done(lat, bcnt, both);
    e = q.pop_front();
    checks++;
    if (lat != 1 || m_sum !== e.sum || m_cout !== e.cout || m_ovf !== e.ovf) begin
      failures++;
      $display("FAIL w1_111 got lat=%0d sum=%h cout=%b ovf=%b exp lat=1 sum=%h cout=%b ovf=%b",
               lat, m_sum, m_cout, m_ovf, e.sum, e.cout, e.ovf);
    end
    @(posedge clk); #1;
    launch(64'h1, 64'h0, 1'b0, 1'b1);
    wait_done(lat, bcnt, both);
    e = q.pop_front();
    checks++;
    if (lat != 1 || m_sum !== e.sum || m_cout !== e.cout || m_ovf !== e.ovf) begin
      failures++;
      $display("FAIL w1_sub10 got lat=%0d sum=%h cout=%b ovf=%b exp lat=1 sum=%h cout=%b ovf=%b",
               lat, m_sum, m_cout, m_ovf, e.sum, e.cout, e.ovf);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    sel      = 0;
    rst      = 1'b0;
    t_start  = 1'b0;
    t_sub    = 1'b0;
    t_cin    = 1'b0;
    t_a      = '0;
    t_b      = '0;
    #2;
    test_reset();
    test_add_carry();
    test_add_ovf_sub();
    test_exhaustive_w3();
    test_busy_ignore();
    test_back_to_back();
    sel = 0;
    launch(64'h05, 64'h07, 1'b0, 1'b1);
    begin
      int lat; int bcnt; bit both; exp_t e;
      wait_done(lat, bcnt, both);
      e = q.pop_front();
      checks++;
      if (m_sum !== e.sum || m_cout !== e.cout || m_ovf !== e.ovf) begin
        failures++;
        $display("FAIL pre_reset_sub got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                 m_sum, m_cout, m_ovf, e.sum, e.cout, e.ovf);
      end
      @(posedge clk); #1;
    end
    test_reset_mid();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
Parametrised bit-serial adder/subtractor and the sequential successor to the single-bit decoder-based full adder. It feeds WIDTH-bit operands LSB-first through one full-adder cell and a carry flip-flop, one bit per clock. A start/busy/done handshake frames each operation. Results are held until the next operation, for use by multi-cycle arithmetic datapaths where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset; clears all state and outputs
start  input  1  request; sampled only when busy=0
sub  input  1  mode, sampled with start: 0 = a+b+cin, 1 = a-b (cin ignored)
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
cin  input  1  carry-in for add mode, sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: sum/cout/ovf have just updated
sum  output  WIDTH  result, held until the next done
cout  output  1  final carry out; in sub mode 1 = no borrow
ovf  output  1  signed overflow, equal to the carry into the MSB XOR the carry out of the MSB

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0, ovf=0
  - shift registers, carry register and bit counter all cleared
  - Deassertion needs no special sequencing; the first edge with rst=0 may accept start.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - latch A_sh=a
  - latch B_sh=(sub ? ~b : b)
  - latch carry=(sub ? 1 : cin)
  - clear cnt to 0, set busy=1, go to RUN
  - With start=0, remain in IDLE.
- RUN: each edge does the following:
  - s = A_sh[0]^B_sh[0]^carry
  - carry <= majority(A_sh[0],B_sh[0],carry)
  - shift A_sh and B_sh right by 1
  - shift s into the MSB of the result shift register
  - cnt <= cnt+1
  - On the edge processing bit WIDTH-1:
    - register the carry-in of that bit as the ovf source
    - load sum from the completed result register (including this bit)
    - cout <= new carry
    - ovf <= carry_in_msb ^ new carry
    - done <= 1, busy <= 0, go to DONE
- DONE: lasts one cycle with done=1.
  - start=1 on this edge begins a new operation exactly as from IDLE (back-to-back, no bubble).
  - Otherwise go to IDLE.
  - done always returns to 0 on this edge.
- Latency: start sampled at edge E. busy=1 after E. done=1 and results valid after edge E+WIDTH. done drops after E+WIDTH+1. Throughput is one result per WIDTH+1 cycles.
- busy and done are never high together.
- start while busy=1 is ignored; it is not queued and operands are not re-sampled.
- sum, cout and ovf change only at the done edge (or on reset). Intermediate shifting is not visible on sum.
- Arithmetic: {cout,sum} == a+b+cin mod 2^(WIDTH+1) in add mode, and a+~b+1 in sub mode. All arithmetic is unsigned modular; ovf gives the signed interpretation.
- WIDTH=1: RUN lasts one edge; ovf = cin_into_bit0 ^ cout.
- The counter needs clog2(WIDTH+1) bits. No combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, add: a=8'hFF, b=8'h01, cin=0, start for 1 cycle -> done pulses exactly 8 edges after the start edge; sum=8'h00, cout=1, ovf=0; busy high for exactly 8 cycles.
- WIDTH=8, add: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1. Then sub: a=8'h05, b=8'h07 -> sum=8'hFE, cout=0 (borrow), ovf=0.
- WIDTH=3, exhaustive: all 64 (a,b) pairs × cin × sub = 256 operations -> each {cout,sum} matches the reference model; ovf matches the signed check. This mirrors the single-bit full-adder truth-table sweep, scaled up.
- Handshake: pulse start again while busy with different operands -> ignored; result corresponds to the first operands. Assert start during the done cycle -> next busy begins on the following edge, with no idle cycle.
- Reset mid-operation: assert rst asynchronously (between edges) at the 4th RUN cycle -> busy, done, sum, cout and ovf go to 0 immediately without waiting for a clock edge. After release, a new operation a=8'h10, b=8'h20 gives sum=8'h30, cout=0.
- WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1, ovf=0 (carry into bit0=1, cout=1); done arrives 1 edge after start.
